axis_event_packer: RTL

- Sits directly downstream of the trigger/timestamp stage.
- Takes its 128-bit event stream {time[61:0], data[65:0]}, which has no back-pressure, and buffers events in a small FIFO.
- Serialises each event into two 64-bit AXI4-Stream beats with tready back-pressure, for a DMA/stream writer.
- Counts events lost to FIFO overflow.

---
 rtl/axis_event_packer.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/axis_event_packer.sv
// -----------------------------------------------------------------------------
// axis_event_packer
//
// Buffers 128-bit events {time[61:0], data[65:0]} from a stream without
// back-pressure in a small FIFO, then serialises each event into two 64-bit
// AXI4-Stream beats (low half first, tlast on the high half). Events arriving
// while the FIFO is full are dropped and counted in a saturating counter.
//
// Optional feature (macro AXIS_EVENT_PACKER_MARKER_EN): a second saturating
// counter tracks drops since the last marker. At the next event boundary a
// two-beat marker {zero-extended count, all ones} is emitted ahead of the
// next FIFO event. With the macro undefined no markers are produced.
//
// Ports:
//   aclk, aresetn       clock, asynchronous active-low reset
//   s_axis_tdata/tvalid event input (no tready, never stalls)
//   m_axis_tdata/tvalid/tready/tlast  64-bit beat output
//   drop_count          total dropped events, saturating
//   fifo_level          current FIFO occupancy (0..DEPTH)
// -----------------------------------------------------------------------------
module axis_event_packer #(
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int DROP_CNT_WIDTH  = 32
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [127:0]               s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic [63:0]                m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [DROP_CNT_WIDTH-1:0]  drop_count,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_level
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0]  LVL_FULL = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};
    localparam logic [FIFO_DEPTH_LOG2:0]  LVL_ZERO = {(FIFO_DEPTH_LOG2+1){1'b0}};
    localparam logic [FIFO_DEPTH_LOG2:0]  LVL_ONE  = {{FIFO_DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE = {{(FIFO_DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DROP_CNT_WIDTH-1:0] CNT_MAX  = {DROP_CNT_WIDTH{1'b1}};
    localparam logic [DROP_CNT_WIDTH-1:0] CNT_ZERO = {DROP_CNT_WIDTH{1'b0}};
    localparam logic [DROP_CNT_WIDTH-1:0] CNT_ONE  = {{(DROP_CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } state_e;

    // Storage and state
    logic [127:0]                mem_q [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH_LOG2:0]    level_q, level_d;
    logic [DROP_CNT_WIDTH-1:0]   drop_count_q, drop_count_d;
    state_e                      state_q, state_d;
    logic [63:0]                 tdata_q, tdata_d;
    logic [63:0]                 hi_q, hi_d;       // second beat, loaded with the first
    logic                        tvalid_q, tvalid_d;
    logic                        tlast_q, tlast_d;

    logic          push_s, drop_s, xfer_s, boundary_s, marker_s, pop_s;
    logic [127:0]  rd_data_s;
    logic [63:0]   marker_beat0_s;

`ifdef AXIS_EVENT_PACKER_MARKER_EN
    logic [DROP_CNT_WIDTH-1:0]   interval_q, interval_d;
`endif

    // Handshake qualifiers; "full" and "non-empty" both use the registered level
    always_comb begin
        push_s     = s_axis_tvalid && (level_q != LVL_FULL);
        drop_s     = s_axis_tvalid && (level_q == LVL_FULL);
        xfer_s     = tvalid_q && m_axis_tready;
        boundary_s = (state_q == ST_IDLE) || ((state_q == ST_HI) && xfer_s);
        rd_data_s  = mem_q[rd_ptr_q];
`ifdef AXIS_EVENT_PACKER_MARKER_EN
        marker_s       = boundary_s && (interval_q != CNT_ZERO);
        marker_beat0_s = 64'(interval_q);
`else
        marker_s       = 1'b0;
        marker_beat0_s = 64'h0000_0000_0000_0000;
`endif
        // A pending marker takes the boundary, leaving the FIFO untouched
        pop_s = boundary_s && !marker_s && (level_q != LVL_ZERO);
    end

    // FIFO pointers, level and drop counters
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        drop_count_d = drop_count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
        if (drop_s && (drop_count_q != CNT_MAX)) begin
            drop_count_d = drop_count_q + CNT_ONE;
        end else begin
            drop_count_d = drop_count_q;
        end
`ifdef AXIS_EVENT_PACKER_MARKER_EN
        interval_d = interval_q;
        if (marker_s) begin
            // Capturing the marker restarts the interval; a drop on the same edge counts
            interval_d = drop_s ? CNT_ONE : CNT_ZERO;
        end else if (drop_s && (interval_q != CNT_MAX)) begin
            interval_d = interval_q + CNT_ONE;
        end else begin
            interval_d = interval_q;
        end
`endif
    end

    // Output beat sequencer: IDLE -> LO (beat0) -> HI (beat1) -> LO or IDLE
    always_comb begin
        state_d  = state_q;
        tdata_d  = tdata_q;
        hi_d     = hi_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        case (state_q)
            ST_IDLE, ST_HI: begin
                if (marker_s) begin
                    tdata_d  = marker_beat0_s;
                    hi_d     = 64'hFFFF_FFFF_FFFF_FFFF;
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    state_d  = ST_LO;
                end else if (pop_s) begin
                    tdata_d  = rd_data_s[63:0];
                    hi_d     = rd_data_s[127:64];
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    state_d  = ST_LO;
                end else if (state_q == ST_HI && xfer_s) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LO: begin
                if (xfer_s) begin
                    tdata_d = hi_q;
                    tlast_d = 1'b1;
                    state_d = ST_HI;
                end else begin
                    state_d = ST_LO;
                end
            end
            default: begin
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // Event storage; contents need no reset since level gates every read
    always_ff @(posedge aclk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= s_axis_tdata;
        end
    end

    // All control and output registers; reset clears outputs without a clock
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q     <= {FIFO_DEPTH_LOG2{1'b0}};
            rd_ptr_q     <= {FIFO_DEPTH_LOG2{1'b0}};
            level_q      <= LVL_ZERO;
            drop_count_q <= CNT_ZERO;
            state_q      <= ST_IDLE;
            tdata_q      <= 64'h0000_0000_0000_0000;
            hi_q         <= 64'h0000_0000_0000_0000;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
`ifdef AXIS_EVENT_PACKER_MARKER_EN
            interval_q   <= CNT_ZERO;
`endif
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            drop_count_q <= drop_count_d;
            state_q      <= state_d;
            tdata_q      <= tdata_d;
            hi_q         <= hi_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
`ifdef AXIS_EVENT_PACKER_MARKER_EN
            interval_q   <= interval_d;
`endif
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign drop_count    = drop_count_q;
    assign fifo_level    = level_q;

endmodule
